// File: rtl/avalon_ram_pipe_if.sv
// ----------------------------------------------------------------------------
// avalon_ram_pipe_if
// Avalon-MM bus bundle between a host and the avalon_ram_pipe memory agent.
//   master modport : drives address/read/write/writedata/byteenable,
//                    observes waitrequest and both response channels.
//   slave modport  : the mirror image, used by the memory agent.
// ----------------------------------------------------------------------------
interface avalon_ram_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic [1:0]          response;
  logic                writeresponsevalid;
  logic [1:0]          writeresponse;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid, response,
           writeresponsevalid, writeresponse
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid, response,
           writeresponsevalid, writeresponse
  );
endinterface

// File: rtl/avalon_ram_pipe.sv
// ----------------------------------------------------------------------------
// avalon_ram_pipe
// Avalon-MM memory endpoint: word RAM with byte enables, fixed-latency
// pipelined reads, write responses, address-range decoding and an optional
// post-reset clear pass during which waitrequest is held high.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : Avalon-MM slave port (address, read, write, writedata, byteenable,
//          waitrequest, readdata, readdatavalid, response,
//          writeresponsevalid, writeresponse)
// Responses: 2'b00 OKAY, 2'b10 SLVERR (read+write together),
//            2'b11 DECODEERROR (address >= DEPTH).
// ----------------------------------------------------------------------------
module avalon_ram_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 2**ADDR_W,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  avalon_ram_pipe_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t           r_state;
  logic             r_waitreq;
  logic [IDX_W-1:0] r_clr_ptr;

  logic             r_wr_vld;
  logic [1:0]       r_wr_resp;

  // Read pipeline: stage 0 captures the array at the accepting edge, the
  // last stage is the registered output. Data/response stages only move
  // when a valid entry moves, so the outputs hold their last value.
  logic [READ_LATENCY-1:0] r_rd_vld;
  logic [DATA_W-1:0]       r_rd_data [READ_LATENCY];
  logic [1:0]              r_rd_resp [READ_LATENCY];

  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_in_range;
  logic              w_illegal;
  logic              w_accept;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_resp;
  logic [DATA_W-1:0] w_rd_data;

  assign w_in_range = ({1'b0, bus.address} < (ADDR_W+1)'(DEPTH));
  assign w_idx      = bus.address[IDX_W-1:0];
  assign w_illegal  = bus.read && bus.write;
  // Acceptance depends only on registered state, so waitrequest never has a
  // combinational path from the bus inputs.
  assign w_accept   = (r_state == ST_READY) && !r_waitreq && (bus.read || bus.write);
  assign w_mem_we   = w_accept && bus.write && !bus.read && w_in_range;

  // One response code serves both channels: the illegal combination wins,
  // then the range decode.
  assign w_resp     = w_illegal  ? RESP_SLVERR :
                      w_in_range ? RESP_OKAY   : RESP_DECERR;
  assign w_rd_data  = (w_illegal || !w_in_range) ? '0 : mem[w_idx];

  // NOTE: the array has no reset branch so it maps onto block RAM; contents
  // survive reset and are zeroed only by the CLEAR pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == ST_CLEAR) begin
        mem[r_clr_ptr] <= '0;
      end else if (w_mem_we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (bus.byteenable[i]) mem[w_idx][i*8 +: 8] <= bus.writedata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_waitreq <= 1'b1;
      r_clr_ptr <= '0;
      r_wr_vld  <= 1'b0;
      r_wr_resp <= RESP_OKAY;
      r_rd_vld  <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_rd_data[k] <= '0;
        r_rd_resp[k] <= RESP_OKAY;
      end
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == CLR_LAST) begin
            r_state   <= ST_READY;
            r_waitreq <= 1'b0;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        ST_READY: r_waitreq <= 1'b0;
        default: begin
          r_state   <= ST_READY;
          r_waitreq <= 1'b0;
        end
      endcase

      r_wr_vld <= w_accept && bus.write;
      if (w_accept && bus.write) r_wr_resp <= w_resp;

      r_rd_vld[0] <= w_accept && bus.read;
      if (w_accept && bus.read) begin
        r_rd_data[0] <= w_rd_data;
        r_rd_resp[0] <= w_resp;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_rd_vld[k] <= r_rd_vld[k-1];
        if (r_rd_vld[k-1]) begin
          r_rd_data[k] <= r_rd_data[k-1];
          r_rd_resp[k] <= r_rd_resp[k-1];
        end
      end
    end
  end

  assign bus.waitrequest        = r_waitreq;
  assign bus.readdatavalid      = r_rd_vld[READ_LATENCY-1];
  assign bus.readdata           = r_rd_data[READ_LATENCY-1];
  assign bus.response           = r_rd_resp[READ_LATENCY-1];
  assign bus.writeresponsevalid = r_wr_vld;
  assign bus.writeresponse      = r_wr_resp;

endmodule

// File: tb/tb_avalon_ram_pipe.sv
// ----------------------------------------------------------------------------
// tb_avalon_ram_pipe
// Self-checking bench for avalon_ram_pipe (DEPTH=12, ADDR_W=4, READ_LATENCY=3,
// CLEAR_ON_RESET=1). Commands push their expected completion (due cycle,
// data, response) into per-channel queues; a negedge monitor pops and
// compares each completion and flags any strobe nobody expected.
// ----------------------------------------------------------------------------
module tb_avalon_ram_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int RL     = 3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        rd_q[$];
  exp_t        wr_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [DEPTH];

  avalon_ram_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  avalon_ram_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Completion monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      mon_e = rd_q.pop_front();
      check("rd_valid", {31'b0, bus.readdatavalid}, 32'd1);
      check("rd_data", bus.readdata, mon_e.data);
      check("rd_resp", {30'b0, bus.response}, {30'b0, mon_e.resp});
    end else if (bus.readdatavalid !== 1'b0) begin
      check("rd_spurious", {31'b0, bus.readdatavalid}, 32'd0);
    end
    if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
      mon_e = wr_q.pop_front();
      check("wr_valid", {31'b0, bus.writeresponsevalid}, 32'd1);
      check("wr_resp", {30'b0, bus.writeresponse}, {30'b0, mon_e.resp});
    end else if (bus.writeresponsevalid !== 1'b0) begin
      check("wr_spurious", {31'b0, bus.writeresponsevalid}, 32'd0);
    end
  end

  // Drive one command for one edge; called at a falling edge, returns at
  // the next falling edge. Only used while waitrequest is low.
  task automatic cmd(input logic rd, input logic wr, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    int          n;
    logic        in_rng;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    n      = cyc + 1;
    in_rng = (int'(a) < DEPTH);
    resp   = (rd && wr) ? SLVERR : (in_rng ? OKAY : DECERR);
    rdata  = (!wr && in_rng) ? ref_mem[a] : 32'h0;
    if (wr) begin
      wr_q.push_back('{n, 32'h0, resp});
      if (!rd && in_rng) ref_mem[a] = merge(ref_mem[a], d, be);
    end
    if (rd) rd_q.push_back('{n + RL - 1, rdata, resp});
    @(posedge clk);
    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Counts edges until waitrequest falls; a clear pass takes DEPTH edges.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.waitrequest !== 1'b0 && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check(tag, n, DEPTH);
  endtask

  initial begin
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq", {31'b0, bus.waitrequest}, 32'd1);
    check("rst_rdvalid", {31'b0, bus.readdatavalid}, 32'd0);
    check("rst_wrvalid", {31'b0, bus.writeresponsevalid}, 32'd0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_response", {30'b0, bus.response}, 32'd0);
    check("rst_wrresp", {30'b0, bus.writeresponse}, 32'd0);
    rst = 1'b1;
    wait_ready("clear_cycles");

    // Every word reads back zero after the clear pass, back-to-back
    for (int a = 0; a < DEPTH; a++) cmd(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
    idle(RL + 1);

    // Byte-enable merge
    cmd(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 4'b1111);
    cmd(1'b0, 1'b1, 4'd3, 32'h11223344, 4'b0101);
    cmd(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    idle(RL + 1);
    check("be_model", ref_mem[3], 32'hDE22BE44);

    // Streaming reads of preloaded words 0..7
    for (int a = 0; a < 8; a++) cmd(1'b0, 1'b1, 4'(a), 32'(a), 4'hF);
    for (int a = 0; a < 8; a++) cmd(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
    idle(RL + 1);

    // Range boundaries and error responses
    cmd(1'b0, 1'b1, 4'd11, 32'hCAFE0011, 4'hF);
    cmd(1'b1, 1'b0, 4'd11, 32'h0, 4'h0);
    cmd(1'b0, 1'b1, 4'd12, 32'h12121212, 4'hF);
    cmd(1'b0, 1'b1, 4'd13, 32'h13131313, 4'hF);
    cmd(1'b1, 1'b0, 4'd13, 32'h0, 4'h0);
    cmd(1'b1, 1'b0, 4'd15, 32'h0, 4'h0);
    cmd(1'b1, 1'b1, 4'd2, 32'hFFFFFFFF, 4'hF);
    cmd(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    cmd(1'b0, 1'b1, 4'd4, 32'hFFFFFFFF, 4'h0);
    cmd(1'b1, 1'b0, 4'd4, 32'h0, 4'h0);

    // Read-after-write on consecutive edges
    cmd(1'b0, 1'b1, 4'd5, 32'hA5A5A5A5, 4'hF);
    cmd(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    idle(RL + 1);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 9);
      cmd(op < 5 || op == 9, op >= 5, 4'($urandom_range(0, 15)), $urandom, 4'($urandom));
    end
    idle(RL + 1);

    // Reset while two reads are in flight: both are discarded
    cmd(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    cmd(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    rd_q.delete();
    wr_q.delete();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_waitreq", {31'b0, bus.waitrequest}, 32'd1);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    // Commands offered during the clear pass must be ignored
    bus.read    = 1'b1;
    bus.write   = 1'b1;
    bus.address = 4'd3;
    wait_ready("reclear_cycles");
    bus.read  = 1'b0;
    bus.write = 1'b0;
    for (int a = 0; a < 4; a++) cmd(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
    idle(RL + 3);

    check("rd_q_drained", rd_q.size(), 32'd0);
    check("wr_q_drained", wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
